// File: rtl/audio_adc_44_1khz_pkg.sv
// Shared definitions for the stereo sigma-delta audio input: default PCM width,
// channel count and the sequencing states.
package audio_adc_44_1khz_pkg;

    localparam int AUDIO_BITS_DEFAULT = 12;
    localparam int NUM_CH             = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/audio_adc_44_1khz_channel.sv
// One sigma-delta channel: comparator synchroniser, 1-bit feedback register and
// a boxcar accumulator whose window total is saturated to AUDIO_BITS.
module audio_adc_44_1khz_channel
    import audio_adc_44_1khz_pkg::*;
#(
    parameter int AUDIO_BITS = AUDIO_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  cmp,
    input  logic                  clear,
    input  logic                  end_of_window,
    output logic                  fb,
    output logic [AUDIO_BITS-1:0] result
);

    logic                s1_reg;
    logic                s2_reg;
    logic                fb_reg;
    logic [AUDIO_BITS:0] acc_reg;
    logic [AUDIO_BITS:0] sum_next;

    // The window total includes the bit being fed back on the closing edge.
    assign sum_next = acc_reg + {{AUDIO_BITS{1'b0}}, s2_reg};
    assign result   = sum_next[AUDIO_BITS] ? {AUDIO_BITS{1'b1}} : sum_next[AUDIO_BITS-1:0];
    assign fb       = fb_reg;

    always_ff @(posedge clk) begin
        if (aclr) begin
            s1_reg  <= 1'b0;
            s2_reg  <= 1'b0;
            fb_reg  <= 1'b0;
            acc_reg <= '0;
        end else begin
            s1_reg <= cmp;
            s2_reg <= s1_reg;
            fb_reg <= s2_reg;
            if (clear || end_of_window) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= sum_next;
            end
        end
    end

endmodule

// File: rtl/audio_adc_44_1khz.sv
// Stereo 1-bit sigma-delta audio input: window sequencing, decimated sample
// register and the valid/overrun handshake towards the consumer.
module audio_adc_44_1khz
    import audio_adc_44_1khz_pkg::*;
#(
    parameter int AUDIO_BITS = AUDIO_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    enable,
    input  logic                    left_cmp,
    input  logic                    right_cmp,
    output logic                    left_fb,
    output logic                    right_fb,
    input  logic                    rreq,
    output logic [2*AUDIO_BITS-1:0] sample,
    output logic                    valid,
    output logic                    overrun
);

    state_t                  state_reg;
    logic [AUDIO_BITS-1:0]   wcnt_reg;
    logic [2*AUDIO_BITS-1:0] sample_reg;
    logic                    valid_reg;
    logic                    overrun_reg;

    logic                    wcnt_max;
    logic                    ch_clear;
    logic                    ch_eow;
    logic                    run_eow;
    logic [NUM_CH-1:0]       cmp_vec;
    logic [NUM_CH-1:0]       fb_vec;
    logic [AUDIO_BITS-1:0]   result_arr [NUM_CH];

    assign wcnt_max = &wcnt_reg;
    assign ch_clear = (state_reg == ST_IDLE) || !enable;
    assign ch_eow   = enable && (state_reg != ST_IDLE) && wcnt_max;
    assign run_eow  = ch_eow && (state_reg == ST_RUN);

    // Index 1 is the left channel so the packed sample keeps left in the upper half.
    assign cmp_vec  = {left_cmp, right_cmp};
    assign left_fb  = fb_vec[1];
    assign right_fb = fb_vec[0];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            audio_adc_44_1khz_channel #(
                .AUDIO_BITS(AUDIO_BITS)
            ) u_ch (
                .clk          (clk),
                .aclr         (aclr),
                .cmp          (cmp_vec[gi]),
                .clear        (ch_clear),
                .end_of_window(ch_eow),
                .fb           (fb_vec[gi]),
                .result       (result_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg   <= ST_IDLE;
            wcnt_reg    <= '0;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (!enable) begin
                state_reg <= ST_IDLE;
                wcnt_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_SETTLE;
                        wcnt_reg  <= '0;
                    end
                    ST_SETTLE: begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                        if (wcnt_max) begin
                            state_reg <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        wcnt_reg  <= '0;
                    end
                endcase
            end

            // A fresh result wins over a same-cycle read; overrun only if the old one went unread.
            if (run_eow) begin
                sample_reg <= {result_arr[1], result_arr[0]};
                valid_reg  <= 1'b1;
                if (valid_reg && !rreq) begin
                    overrun_reg <= 1'b1;
                end
            end else if (rreq && valid_reg) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign sample  = sample_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule
